// File: rtl/cmd_phy_if.sv
// Handshake and pin bundle between the SD CMD control block and its physical layer.
interface cmd_phy_if;
  logic         strobe_in;
  logic         ack_in;
  logic         idle_in;
  logic [39:0]  cmd_to_send;
  logic [1:0]   resp_type;
  logic         timeout_enable;
  logic         cmd_pin_in;
  logic         serial_ready;
  logic         strobe_out;
  logic         ack_out;
  logic [135:0] cmd_received;
  logic         time_out;
  logic         crc_error;
  logic         cmd_pin_out;
  logic         cmd_pin_oe;

  modport master (
    output strobe_in, ack_in, idle_in, cmd_to_send, resp_type, timeout_enable, cmd_pin_in,
    input  serial_ready, strobe_out, ack_out, cmd_received, time_out, crc_error,
           cmd_pin_out, cmd_pin_oe
  );

  modport slave (
    input  strobe_in, ack_in, idle_in, cmd_to_send, resp_type, timeout_enable, cmd_pin_in,
    output serial_ready, strobe_out, ack_out, cmd_received, time_out, crc_error,
           cmd_pin_out, cmd_pin_oe
  );
endinterface

// File: rtl/cmd_phy.sv
// SD CMD line PHY: serialises a 48-bit command frame with CRC7, then captures
// and CRC-checks a 48- or 136-bit response, one bit per card clock.
module cmd_phy #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic     clock,
  input  logic     reset,
  cmd_phy_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t         state;
  logic [39:0]    tx_sr;
  logic [6:0]     crc;
  logic [7:0]     cnt;
  logic [TW-1:0]  tcnt;
  logic           resp_none;
  logic           resp_long;
  logic [135:0]   rx;

  logic [7:0]     rx_last;
  logic [7:0]     crc_lo;
  logic [7:0]     crc_hi;
  logic           rx_in_crc;

  // x^7 + x^3 + 1, MSB-first serial update
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // cnt counts bits already received; 136-bit responses skip the 8-bit header in the CRC
  assign rx_last   = resp_long ? 8'd135 : 8'd47;
  assign crc_lo    = resp_long ? 8'd8   : 8'd0;
  assign crc_hi    = resp_long ? 8'd128 : 8'd40;
  assign rx_in_crc = (cnt >= crc_lo) && (cnt < crc_hi);

  assign bus.cmd_received = rx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      tx_sr            <= '0;
      crc              <= '0;
      cnt              <= '0;
      tcnt             <= '0;
      resp_none        <= 1'b0;
      resp_long        <= 1'b0;
      rx               <= '0;
      bus.serial_ready <= 1'b1;
      bus.strobe_out   <= 1'b0;
      bus.ack_out      <= 1'b0;
      bus.time_out     <= 1'b0;
      bus.crc_error    <= 1'b0;
      bus.cmd_pin_out  <= 1'b1;
      bus.cmd_pin_oe   <= 1'b0;
    end else begin
      bus.ack_out <= 1'b0;
      if (bus.idle_in) begin
        state            <= IDLE;
        bus.cmd_pin_oe   <= 1'b0;
        bus.cmd_pin_out  <= 1'b1;
        bus.strobe_out   <= 1'b0;
        bus.serial_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.strobe_in) begin
              // first frame bit goes out on this edge
              tx_sr            <= {bus.cmd_to_send[38:0], 1'b0};
              crc              <= crc7_step(7'd0, bus.cmd_to_send[39]);
              bus.cmd_pin_out  <= bus.cmd_to_send[39];
              bus.cmd_pin_oe   <= 1'b1;
              cnt              <= '0;
              resp_none        <= (bus.resp_type == 2'b00);
              resp_long        <= (bus.resp_type == 2'b10);
              rx               <= '0;
              bus.time_out     <= 1'b0;
              bus.crc_error    <= 1'b0;
              bus.serial_ready <= 1'b0;
              state            <= SEND;
            end
          end

          SEND: begin
            cnt <= cnt + 8'd1;
            if (cnt < 8'd39) begin
              bus.cmd_pin_out <= tx_sr[39];
              tx_sr           <= {tx_sr[38:0], 1'b0};
              crc             <= crc7_step(crc, tx_sr[39]);
            end else if (cnt < 8'd46) begin
              bus.cmd_pin_out <= crc[6];
              crc             <= {crc[5:0], 1'b0};
            end else if (cnt == 8'd46) begin
              bus.cmd_pin_out <= 1'b1;
            end else begin
              bus.cmd_pin_oe  <= 1'b0;
              bus.cmd_pin_out <= 1'b1;
              tcnt            <= '0;
              cnt             <= '0;
              if (resp_none) begin
                bus.strobe_out <= 1'b1;
                state          <= DONE;
              end else begin
                state <= WAIT_RESP;
              end
            end
          end

          WAIT_RESP: begin
            // a start bit on the deadline clock still wins
            if (!bus.cmd_pin_in) begin
              rx    <= {rx[134:0], 1'b0};
              crc   <= '0;
              cnt   <= 8'd1;
              state <= RECEIVE;
            end else if (bus.timeout_enable && tcnt >= TCNT_LAST) begin
              bus.time_out   <= 1'b1;
              bus.strobe_out <= 1'b1;
              state          <= DONE;
            end else if (tcnt < TCNT_LAST) begin
              tcnt <= tcnt + 1'b1;
            end
          end

          RECEIVE: begin
            rx  <= {rx[134:0], bus.cmd_pin_in};
            cnt <= cnt + 8'd1;
            if (rx_in_crc)
              crc <= crc7_step(crc, bus.cmd_pin_in);
            if (cnt == rx_last) begin
              // rx[6:0] already holds response bits 7..1
              bus.crc_error  <= (crc != rx[6:0]);
              bus.strobe_out <= 1'b1;
              state          <= DONE;
            end
          end

          DONE: begin
            if (bus.ack_in) begin
              bus.ack_out      <= 1'b1;
              bus.strobe_out   <= 1'b0;
              bus.serial_ready <= 1'b1;
              state            <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_phy.sv
// Scoreboard bench for cmd_phy: expected frames/responses are queued at stimulus
// time and popped when the PHY shows them on the pin or on strobe_out.
module tb_cmd_phy;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cmd_phy_if bus();

  cmd_phy #(.TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [135:0] exp_q[$];

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = c[6] ^ v[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] frame48(input logic [39:0] c);
    return {c, crc7({96'd0, c}, 39, 0), 1'b1};
  endfunction

  task automatic pop_chk(input string tag, input logic [135:0] obs);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h want <empty scoreboard>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  // strobe a command and capture the 48 bits the PHY drives
  task automatic send(input logic [39:0] c, input logic [1:0] rt, input logic [47:0] fexp);
    logic [47:0] tx;
    logic        oe_ok;
    exp_q.push_back({88'd0, fexp});
    bus.cmd_to_send = c;
    bus.resp_type   = rt;
    bus.strobe_in   = 1'b1;
    step();
    bus.strobe_in = 1'b0;
    chk("busy_ready", bus.serial_ready, 1'b0);
    tx    = '0;
    oe_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (bus.cmd_pin_oe !== 1'b1) oe_ok = 1'b0;
      tx = {tx[46:0], bus.cmd_pin_out};
      step();
    end
    chk("tx_oe", oe_ok, 1'b1);
    pop_chk("tx_frame", tx);
    chk("oe_release", bus.cmd_pin_oe, 1'b0);
    chk("pin_release", bus.cmd_pin_out, 1'b1);
  endtask

  task automatic respond(input logic [135:0] r, input int n, input int dly);
    for (int d = 0; d < dly; d++) begin
      bus.cmd_pin_in = 1'b1;
      step();
    end
    for (int i = n - 1; i >= 0; i--) begin
      bus.cmd_pin_in = r[i];
      step();
    end
    bus.cmd_pin_in = 1'b1;
  endtask

  task automatic result(input logic to, input logic ce);
    chk("strobe_out", bus.strobe_out, 1'b1);
    pop_chk("cmd_received", bus.cmd_received);
    chk("time_out", bus.time_out, to);
    chk("crc_error", bus.crc_error, ce);
  endtask

  task automatic ack();
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    chk("ack_out", bus.ack_out, 1'b1);
    chk("ack_strobe", bus.strobe_out, 1'b0);
    chk("ack_ready", bus.serial_ready, 1'b1);
    step();
    chk("ack_pulse", bus.ack_out, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.serial_ready, 1'b1);
    chk({tag, "_pin"},   bus.cmd_pin_out, 1'b1);
    chk({tag, "_oe"},    bus.cmd_pin_oe, 1'b0);
    chk({tag, "_strb"},  bus.strobe_out, 1'b0);
    chk({tag, "_ack"},   bus.ack_out, 1'b0);
    chk({tag, "_to"},    bus.time_out, 1'b0);
    chk({tag, "_crc"},   bus.crc_error, 1'b0);
    chk({tag, "_rx"},    bus.cmd_received, 136'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0]  c;
    logic [47:0]  r48;
    logic [135:0] r136;
    int           wait_cnt;

    bus.strobe_in      = 1'b0;
    bus.ack_in         = 1'b0;
    bus.idle_in        = 1'b0;
    bus.cmd_to_send    = '0;
    bus.resp_type      = 2'b00;
    bus.timeout_enable = 1'b1;
    bus.cmd_pin_in     = 1'b1;

    step(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // CMD0, no response
    send(40'h4000000000, 2'b00, 48'h400000000095);
    exp_q.push_back(136'd0);
    result(1'b0, 1'b0);
    step(3);
    chk("done_hold", bus.strobe_out, 1'b1);
    ack();

    // CMD8 with R7 response 10 clocks later
    send(40'h48000001AA, 2'b01, 48'h48000001AA87);
    exp_q.push_back({88'd0, 48'h08000001AA13});
    respond({88'd0, 48'h08000001AA13}, 48, 10);
    result(1'b0, 1'b0);
    ack();
    chk("idle_keep_rx", bus.cmd_received, {88'd0, 48'h08000001AA13});

    // same with response bit 1 flipped
    send(40'h48000001AA, 2'b01, 48'h48000001AA87);
    exp_q.push_back({88'd0, 48'h08000001AA11});
    respond({88'd0, 48'h08000001AA11}, 48, 10);
    result(1'b0, 1'b1);
    ack();

    // start bit lands on the deadline clock, resp_type 11 acts as 48-bit
    c   = {2'b01, 6'(($urandom % 64)), 32'($urandom)};
    r48 = {2'b00, 6'd17, 32'hDEADBEEF, crc7({96'd0, 2'b00, 6'd17, 32'hDEADBEEF}, 39, 0), 1'b1};
    send(c, 2'b11, frame48(c));
    exp_q.push_back({88'd0, r48});
    respond({88'd0, r48}, 48, TO - 1);
    result(1'b0, 1'b0);
    ack();

    // timeout with the line held high
    c = {2'b01, 6'd13, 32'h0001_0000};
    send(c, 2'b01, frame48(c));
    wait_cnt = 0;
    while (bus.strobe_out !== 1'b1 && wait_cnt < TO + 50) begin
      step();
      wait_cnt++;
    end
    chk("timeout_lat", wait_cnt, TO);
    exp_q.push_back(136'd0);
    result(1'b1, 1'b0);
    ack();

    // timeout disabled: still waiting after 1000 clocks, then abort
    bus.timeout_enable = 1'b0;
    send(c, 2'b01, frame48(c));
    step(1000);
    chk("notimeout_strb", bus.strobe_out, 1'b0);
    chk("notimeout_ready", bus.serial_ready, 1'b0);
    bus.idle_in = 1'b1;
    step();
    bus.idle_in = 1'b0;
    chk("abort_wait_ready", bus.serial_ready, 1'b1);
    chk("abort_wait_ack", bus.ack_out, 1'b0);
    bus.timeout_enable = 1'b1;

    // 136-bit response with a valid internal CRC
    r136[135:128] = 8'h3F;
    r136[127:8]   = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 24'h4B5A69};
    r136[7:1]     = crc7(r136, 127, 8);
    r136[0]       = 1'b1;
    c = {2'b01, 6'd2, 32'd0};
    send(c, 2'b10, frame48(c));
    exp_q.push_back(r136);
    respond(r136, 136, 5);
    result(1'b0, 1'b0);
    ack();

    // idle_in during SEND bit 20
    bus.cmd_to_send = 40'h4000000000;
    bus.resp_type   = 2'b01;
    bus.strobe_in   = 1'b1;
    step();
    bus.strobe_in = 1'b0;
    step(20);
    bus.idle_in = 1'b1;
    step();
    bus.idle_in = 1'b0;
    chk("abort_tx_oe", bus.cmd_pin_oe, 1'b0);
    chk("abort_tx_ready", bus.serial_ready, 1'b1);
    chk("abort_tx_pin", bus.cmd_pin_out, 1'b1);
    chk("abort_tx_strb", bus.strobe_out, 1'b0);
    step(3);
    chk("abort_tx_stay", bus.cmd_pin_oe, 1'b0);

    // async reset partway through RECEIVE
    c = {2'b01, 6'd55, 32'd0};
    send(c, 2'b01, frame48(c));
    bus.cmd_pin_in = 1'b0;
    step();
    bus.cmd_pin_in = 1'b1;
    step(10);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    #10 reset = 1'b0;
    step();
    chk("arst_idle_oe", bus.cmd_pin_oe, 1'b0);

    // strobe_in during DONE is ignored
    send(40'h4000000000, 2'b00, 48'h400000000095);
    bus.cmd_to_send = 40'h7FFFFFFFFF;
    bus.strobe_in   = 1'b1;
    step(3);
    bus.strobe_in = 1'b0;
    chk("done_strobe_oe", bus.cmd_pin_oe, 1'b0);
    chk("done_strobe_ready", bus.serial_ready, 1'b0);
    exp_q.push_back(136'd0);
    result(1'b0, 1'b0);
    ack();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
